// File: rtl/seq_adder_if.sv
// Start/busy/done handshake and operand/result bus for seq_adder.
// The sat request line exists only when SEQ_ADDER_SAT_EN is defined.
interface seq_adder_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] ain;
    logic [WIDTH-1:0] bin;
    logic             sub;
`ifdef SEQ_ADDER_SAT_EN
    logic             sat;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] add_out;
    logic             carry_out;
    logic             overflow;

`ifdef SEQ_ADDER_SAT_EN
    modport master (output start, ain, bin, sub, sat,
                    input  busy, done, add_out, carry_out, overflow);
    modport slave  (input  start, ain, bin, sub, sat,
                    output busy, done, add_out, carry_out, overflow);
`else
    modport master (output start, ain, bin, sub,
                    input  busy, done, add_out, carry_out, overflow);
    modport slave  (input  start, ain, bin, sub,
                    output busy, done, add_out, carry_out, overflow);
`endif
endinterface

// File: rtl/seq_adder.sv
// Multi-cycle add/subtract, one CHUNK-bit slice per clock, start/busy/done handshake.
// Define SEQ_ADDER_SAT_EN to add signed saturation controlled by the latched sat bit.
module seq_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic          clk,
    input  logic          rst,
    seq_adder_if.slave    bus
);
    localparam int N  = WIDTH / CHUNK;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             c_q, c_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [WIDTH-1:0] add_out_q, add_out_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
`ifdef SEQ_ADDER_SAT_EN
    logic             sat_q, sat_d;
`endif

    int               base;
    logic [CHUNK:0]   slice;
    logic [WIDTH-1:0] full;
    logic             ovf_raw;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            k_q       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            c_q       <= 1'b0;
            shadow_q  <= '0;
            add_out_q <= '0;
            carry_q   <= 1'b0;
            ovf_q     <= 1'b0;
`ifdef SEQ_ADDER_SAT_EN
            sat_q     <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking updates so every register samples pre-edge values of the others.
            state_q   <= state_d;
            k_q       <= k_d;
            a_q       <= a_d;
            b_q       <= b_d;
            c_q       <= c_d;
            shadow_q  <= shadow_d;
            add_out_q <= add_out_d;
            carry_q   <= carry_d;
            ovf_q     <= ovf_d;
`ifdef SEQ_ADDER_SAT_EN
            sat_q     <= sat_d;
`endif
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d   = state_q;
        k_d       = k_q;
        a_d       = a_q;
        b_d       = b_q;
        c_d       = c_q;
        shadow_d  = shadow_q;
        add_out_d = add_out_q;
        carry_d   = carry_q;
        ovf_d     = ovf_q;
`ifdef SEQ_ADDER_SAT_EN
        sat_d     = sat_q;
`endif

        base  = int'(k_q) * CHUNK;
        slice = {1'b0, a_q[base +: CHUNK]} + {1'b0, b_q[base +: CHUNK]}
              + {{CHUNK{1'b0}}, c_q};
        full  = shadow_q;
        full[base +: CHUNK] = slice[CHUNK-1:0];
        // Overflow uses the inverted B so subtraction needs no separate rule.
        ovf_raw = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (full[WIDTH-1] != a_q[WIDTH-1]);

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d = RUN;
                    k_d     = '0;
                    a_d     = bus.ain;
                    b_d     = bus.sub ? ~bus.bin : bus.bin;
                    c_d     = bus.sub;
`ifdef SEQ_ADDER_SAT_EN
                    sat_d   = bus.sat;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                shadow_d = full;
                c_d      = slice[CHUNK];
                if (k_q == KW'(N - 1)) begin
                    state_d   = DONE;
                    add_out_d = full;
                    carry_d   = slice[CHUNK];
                    ovf_d     = ovf_raw;
`ifdef SEQ_ADDER_SAT_EN
                    if (sat_q && ovf_raw)
                        add_out_d = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                                 : {1'b0, {(WIDTH-1){1'b1}}};
`endif
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // busy excludes the first RUN cycle, so a single-slice unit never raises it.
    assign bus.busy      = (state_q == RUN) && (k_q != '0);
    assign bus.done      = (state_q == DONE);
    assign bus.add_out   = add_out_q;
    assign bus.carry_out = carry_q;
    assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_seq_adder.sv
// Directed bench for seq_adder: a CHUNK=8 and a CHUNK=32 instance, 32-bit operands.
module tb_seq_adder;
    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    seq_adder_if #(.WIDTH(32)) if8  ();
    seq_adder_if #(.WIDTH(32)) if32 ();

    seq_adder #(.WIDTH(32), .CHUNK(8))  dut8  (.clk(clk), .rst(rst), .bus(if8));
    seq_adder #(.WIDTH(32), .CHUNK(32)) dut32 (.clk(clk), .rst(rst), .bus(if32));

    // Drive operands and hold start over one rising edge; returns at the following falling edge.
    task automatic launch(input bit sel, input logic [31:0] a, input logic [31:0] b,
                          input bit s, input bit sat);
        if (sel) begin
            if32.ain = a; if32.bin = b; if32.sub = s; if32.start = 1'b1;
        end else begin
            if8.ain = a; if8.bin = b; if8.sub = s; if8.start = 1'b1;
        end
`ifdef SEQ_ADDER_SAT_EN
        if8.sat  = sat;
        if32.sat = sat;
`else
        if (sat) $display("note: sat requested but SEQ_ADDER_SAT_EN is not defined");
`endif
        @(posedge clk);
        @(negedge clk);
        if8.start  = 1'b0;
        if32.start = 1'b0;
    endtask

    // Counts rising edges until done is seen (lat=-1 on timeout) and falling-edge samples with busy high.
    task automatic wait_done(input bit sel, output int lat, output int busy_cnt);
        lat      = -1;
        busy_cnt = (sel ? if32.busy : if8.busy) ? 1 : 0;
        for (int i = 1; i <= 32; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (sel ? if32.done : if8.done) begin
                lat = i;
                break;
            end
            if (sel ? if32.busy : if8.busy) busy_cnt++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        if8.start = 1'b0;  if8.ain = '0;  if8.bin = '0;  if8.sub = 1'b0;
        if32.start = 1'b0; if32.ain = '0; if32.bin = '0; if32.sub = 1'b0;
`ifdef SEQ_ADDER_SAT_EN
        if8.sat = 1'b0; if32.sat = 1'b0;
`endif
        repeat (2) @(negedge clk);
        checks++;
        if ({if8.busy, if8.done, if8.carry_out, if8.overflow, if8.add_out} !== 36'h0) begin
            errors++;
            $display("FAIL reset_dut8: got busy=%b done=%b c=%b v=%b out=%h, want all zero",
                     if8.busy, if8.done, if8.carry_out, if8.overflow, if8.add_out);
        end
        checks++;
        if ({if32.busy, if32.done, if32.carry_out, if32.overflow, if32.add_out} !== 36'h0) begin
            errors++;
            $display("FAIL reset_dut32: got busy=%b done=%b c=%b v=%b out=%h, want all zero",
                     if32.busy, if32.done, if32.carry_out, if32.overflow, if32.add_out);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Run one CHUNK=8 operation and compare latency and flags.
    task automatic run_and_check(input string name, input logic [31:0] a, input logic [31:0] b,
                                 input bit s, input bit sat, input logic [31:0] exp_out,
                                 input bit exp_c, input bit exp_v);
        int lat, bc;
        launch(1'b0, a, b, s, sat);
        wait_done(1'b0, lat, bc);
        checks++;
        if (lat !== 4 || if8.add_out !== exp_out || if8.carry_out !== exp_c
            || if8.overflow !== exp_v) begin
            errors++;
            $display("FAIL %s: got lat=%0d out=%h c=%b v=%b, want lat=4 out=%h c=%b v=%b",
                     name, lat, if8.add_out, if8.carry_out, if8.overflow, exp_out, exp_c, exp_v);
        end
    endtask

    task automatic test_basic_add();
        int lat, bc;
        launch(1'b0, 32'd2, 32'd2, 1'b0, 1'b0);
        wait_done(1'b0, lat, bc);
        checks++;
        if (lat !== 4) begin
            errors++; $display("FAIL add_latency: got %0d, want 4", lat);
        end
        checks++;
        if (bc !== 3) begin
            errors++; $display("FAIL add_busy_cycles: got %0d, want 3", bc);
        end
        checks++;
        if (if8.add_out !== 32'd4 || if8.carry_out !== 1'b0 || if8.overflow !== 1'b0) begin
            errors++;
            $display("FAIL add_result: got out=%h c=%b v=%b, want 4 0 0",
                     if8.add_out, if8.carry_out, if8.overflow);
        end
        @(negedge clk);
        checks++;
        if (if8.done !== 1'b0 || if8.add_out !== 32'd4) begin
            errors++;
            $display("FAIL done_pulse_width: got done=%b out=%h, want done=0 out=4",
                     if8.done, if8.add_out);
        end
    endtask

    task automatic test_sub();
        run_and_check("sub_10_9", 32'd10, 32'd9, 1'b1, 1'b0, 32'd1, 1'b1, 1'b0);
        run_and_check("sub_0_1", 32'd0, 32'd1, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    endtask

    task automatic test_carry_overflow();
        run_and_check("carry_wrap", 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        run_and_check("pos_ovf_wrap", 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
`ifdef SEQ_ADDER_SAT_EN
        run_and_check("pos_ovf_sat", 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1);
        run_and_check("neg_ovf_sat", 32'h8000_0000, 32'd1, 1'b1, 1'b1, 32'h8000_0000, 1'b1, 1'b1);
`else
        run_and_check("neg_ovf_wrap", 32'h8000_0000, 32'd1, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1);
`endif
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        logic [31:0] prev;
        prev = if8.add_out;
        launch(1'b0, 32'd100, 32'd23, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        if8.ain = 32'd7; if8.bin = 32'd7; if8.sub = 1'b1; if8.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if8.start = 1'b0;
        checks++;
        if (if8.add_out !== prev) begin
            errors++; $display("FAIL hold_during_run: got %h, want %h", if8.add_out, prev);
        end
        wait_done(1'b0, lat, bc);
        checks++;
        if (lat !== 2 || if8.add_out !== 32'd123) begin
            errors++;
            $display("FAIL start_in_run_ignored: got lat=%0d out=%h, want lat=2 out=0000007b",
                     lat, if8.add_out);
        end
        launch(1'b0, 32'd1, 32'd0, 1'b0, 1'b0);
        checks++;
        if (if8.done !== 1'b0 || if8.add_out !== 32'd123) begin
            errors++;
            $display("FAIL b2b_hold: got done=%b out=%h, want done=0 out=0000007b",
                     if8.done, if8.add_out);
        end
        wait_done(1'b0, lat, bc);
        checks++;
        if (lat !== 4 || if8.add_out !== 32'd1) begin
            errors++;
            $display("FAIL b2b_result: got lat=%0d out=%h, want lat=4 out=00000001",
                     lat, if8.add_out);
        end
    endtask

    task automatic test_abort();
        int lat, bc, seen;
        launch(1'b0, 32'd5, 32'd6, 1'b0, 1'b0);
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({if8.busy, if8.done, if8.carry_out, if8.overflow, if8.add_out} !== 36'h0) begin
            errors++;
            $display("FAIL abort_clear: got busy=%b done=%b c=%b v=%b out=%h, want all zero",
                     if8.busy, if8.done, if8.carry_out, if8.overflow, if8.add_out);
        end
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (if8.done || if8.busy) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++; $display("FAIL abort_no_done: got %0d active cycles, want 0", seen);
        end
        launch(1'b0, 32'd5, 32'd6, 1'b0, 1'b0);
        wait_done(1'b0, lat, bc);
        checks++;
        if (lat !== 4 || if8.add_out !== 32'd11) begin
            errors++;
            $display("FAIL after_abort: got lat=%0d out=%h, want lat=4 out=0000000b",
                     lat, if8.add_out);
        end
    endtask

    task automatic test_single_slice();
        int lat, bc;
        launch(1'b1, 32'd10, 32'd9, 1'b0, 1'b0);
        wait_done(1'b1, lat, bc);
        checks++;
        if (lat !== 1 || bc !== 0) begin
            errors++;
            $display("FAIL single_timing: got lat=%0d busy=%0d, want lat=1 busy=0", lat, bc);
        end
        checks++;
        if (if32.add_out !== 32'd19 || if32.carry_out !== 1'b0 || if32.overflow !== 1'b0) begin
            errors++;
            $display("FAIL single_result: got out=%h c=%b v=%b, want 00000013 0 0",
                     if32.add_out, if32.carry_out, if32.overflow);
        end
    endtask

    initial begin
        test_reset();
        test_basic_add();
        test_sub();
        test_carry_overflow();
        test_back_to_back();
        test_abort();
        test_single_slice();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
